// File: rtl/led_pattern_sequencer_if.sv
// LED sequencer pin bundle.
// Groups the board-side button/pause inputs and the LED, mode and tick
// outputs so the sequencer and its driver can share one connection.
//   master : drives i_btn/i_pause, observes LEDs, mode and tick (board / bench side)
//   slave  : the sequencer itself
//   i_btn    raw mode button, asynchronous, 1 = pressed
//   i_pause  1 = hold prescaler and pattern
//   o_led1..o_led4  leds[0]..leds[3]
//   o_mode   current mode: 0 BOUNCE, 1 BLINK, 2 FILL, 3 ALT
//   o_tick   one-cycle pulse in the cycle the pattern advanced
interface led_pattern_sequencer_if;
    logic       i_btn;
    logic       i_pause;
    logic       o_led1;
    logic       o_led2;
    logic       o_led3;
    logic       o_led4;
    logic [1:0] o_mode;
    logic       o_tick;

    modport master (
        output i_btn,
        output i_pause,
        input  o_led1,
        input  o_led2,
        input  o_led3,
        input  o_led4,
        input  o_mode,
        input  o_tick
    );

    modport slave (
        input  i_btn,
        input  i_pause,
        output o_led1,
        output o_led2,
        output o_led3,
        output o_led4,
        output o_mode,
        output o_tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// 4-LED bank controller.
// Owns the pattern-step prescaler, a button synchronizer/debouncer and the
// mode FSM that selects between bounce, blink, fill and alternate patterns.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset (released synchronously upstream)
//   bus  led_pattern_sequencer_if.slave: i_btn, i_pause in; o_led1..4, o_mode, o_tick out
// Parameters:
//   TICK_DIV      clk cycles per pattern step (>= 2)
//   DEBOUNCE_CYC  stable cycles needed to accept a new button level (>= 2)
//
// Mode FSM states:
//   state  | meaning
//   BOUNCE | one-hot LED bounces between leds[0] and leds[3]
//   BLINK  | all LEDs toggle together
//   FILL   | LEDs fill from leds[0] up, then clear
//   ALT    | alternating 0101 / 1010
module led_pattern_sequencer #(
    parameter int TICK_DIV     = 30000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    led_pattern_sequencer_if.slave   bus
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        BLINK  = 2'd1,
        FILL   = 2'd2,
        ALT    = 2'd3
    } mode_e;

    logic             sync1_q, sync1_d;
    logic             btn_s_q, btn_s_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       leds_q, leds_d;
    logic             dir_up_q, dir_up_d;
    mode_e            mode_q, mode_d;
    logic             tick_q, tick_d;

    logic             adv;
    logic             wrap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            pre_q     <= '0;
            leds_q    <= 4'b0001;
            dir_up_q  <= 1'b1;
            mode_q    <= BOUNCE;
            tick_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            btn_s_q   <= btn_s_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            pre_q     <= pre_d;
            leds_q    <= leds_d;
            dir_up_q  <= dir_up_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
        end
    end

    // Button path: the debounce counter only runs while the synchronized
    // level disagrees with the accepted level, so any glitch that returns
    // before DEBOUNCE_CYC cycles clears it. Only an accepted press advances.
    always_comb begin
        sync1_d   = bus.i_btn;
        btn_s_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        adv       = 1'b0;
        if (btn_s_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = btn_s_q;
                adv   = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Next-state: mode FSM
    always_comb begin
        mode_d = mode_q;
        if (adv) begin
            case (mode_q)
                BOUNCE:  mode_d = BLINK;
                BLINK:   mode_d = FILL;
                FILL:    mode_d = ALT;
                ALT:     mode_d = BOUNCE;
                default: mode_d = BOUNCE;
            endcase
        end
    end

    // Next-state: prescaler and pattern. A mode advance restarts the new
    // pattern from its initial value and discards any coincident step.
    always_comb begin
        wrap     = (pre_q == PRE_LAST) && !bus.i_pause;
        pre_d    = pre_q;
        leds_d   = leds_q;
        dir_up_d = dir_up_q;
        tick_d   = 1'b0;
        if (adv) begin
            pre_d    = '0;
            dir_up_d = 1'b1;
            case (mode_d)
                BOUNCE:  leds_d = 4'b0001;
                BLINK:   leds_d = 4'b1111;
                FILL:    leds_d = 4'b0000;
                ALT:     leds_d = 4'b0101;
                default: leds_d = 4'b0001;
            endcase
        end else if (wrap) begin
            pre_d  = '0;
            tick_d = 1'b1;
            case (mode_q)
                BOUNCE: begin
                    // Reverse at the ends so the bank is always one-hot.
                    if (dir_up_q) begin
                        if (leds_q[3]) begin
                            leds_d   = 4'b0100;
                            dir_up_d = 1'b0;
                        end else begin
                            leds_d = {leds_q[2:0], 1'b0};
                        end
                    end else begin
                        if (leds_q[0]) begin
                            leds_d   = 4'b0010;
                            dir_up_d = 1'b1;
                        end else begin
                            leds_d = {1'b0, leds_q[3:1]};
                        end
                    end
                end
                FILL:    leds_d = (leds_q == 4'b1111) ? 4'b0000 : {leds_q[2:0], 1'b1};
                default: leds_d = ~leds_q;
            endcase
        end else if (!bus.i_pause) begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Outputs: straight from flops
    always_comb begin
        bus.o_led1 = leds_q[0];
        bus.o_led2 = leds_q[1];
        bus.o_led3 = leds_q[2];
        bus.o_led4 = leds_q[3];
        bus.o_mode = mode_q;
        bus.o_tick = tick_q;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    led_pattern_sequencer_if bus ();

    led_pattern_sequencer #(
        .TICK_DIV     (4),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] leds();
        return {bus.o_led4, bus.o_led3, bus.o_led2, bus.o_led1};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.i_btn   = 1'b0;
        bus.i_pause = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_leds", {4'b0, leds()}, 8'h01);
        chk("rst_mode", {6'b0, bus.o_mode}, 8'h00);
        chk("rst_tick", {7'b0, bus.o_tick}, 8'h00);
        step(2);
        rst = 1'b0;
    endtask

    logic [3:0] exp_b [12];
    logic [3:0] exp_f [5];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_btn = 1'b0;
        bus.i_pause = 1'b0;
        exp_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                  4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_f = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};

        // 1: idle bounce sequence
        do_reset();
        step(3);
        chk("t1_pre_leds", {4'b0, leds()}, 8'h01);
        chk("t1_pre_tick", {7'b0, bus.o_tick}, 8'h00);
        step(1);
        chk("t1_step0", {4'b0, leds()}, {4'b0, exp_b[0]});
        chk("t1_tick0", {7'b0, bus.o_tick}, 8'h01);
        step(1);
        chk("t1_tick_drop", {7'b0, bus.o_tick}, 8'h00);
        step(3);
        chk("t1_step1", {4'b0, leds()}, {4'b0, exp_b[1]});
        for (int i = 2; i < 12; i++) begin
            step(4);
            chk("t1_step", {4'b0, leds()}, {4'b0, exp_b[i]});
            chk("t1_tick", {7'b0, bus.o_tick}, 8'h01);
        end

        // 2: held press advances exactly once
        bus.i_btn = 1'b1;
        step(4);
        chk("t2_mode_before", {6'b0, bus.o_mode}, 8'h00);
        chk("t2_leds_before", {4'b0, leds()}, 8'h02);
        step(1);
        chk("t2_mode_adv", {6'b0, bus.o_mode}, 8'h01);
        chk("t2_leds_adv", {4'b0, leds()}, 8'h0f);
        chk("t2_tick_adv", {7'b0, bus.o_tick}, 8'h00);
        step(100);
        chk("t2_mode_hold", {6'b0, bus.o_mode}, 8'h01);
        bus.i_btn = 1'b0;
        step(10);
        chk("t2_mode_release", {6'b0, bus.o_mode}, 8'h01);

        // 3: short bounces are rejected (paused so leds are static)
        do_reset();
        bus.i_pause = 1'b1;
        for (int r = 0; r < 5; r++) begin
            bus.i_btn = 1'b1;
            step(2);
            bus.i_btn = 1'b0;
            step(3);
            chk("t3_mode", {6'b0, bus.o_mode}, 8'h00);
            chk("t3_leds", {4'b0, leds()}, 8'h01);
        end
        step(6);
        chk("t3_mode_end", {6'b0, bus.o_mode}, 8'h00);
        chk("t3_tick_end", {7'b0, bus.o_tick}, 8'h00);
        bus.i_pause = 1'b0;

        // 4: four clean presses
        do_reset();
        bus.i_btn = 1'b1;
        step(5);
        chk("t4_blink_mode", {6'b0, bus.o_mode}, 8'h01);
        chk("t4_blink_init", {4'b0, leds()}, 8'h0f);
        step(4);
        chk("t4_blink_s1", {4'b0, leds()}, 8'h00);
        chk("t4_blink_tick", {7'b0, bus.o_tick}, 8'h01);
        step(4);
        chk("t4_blink_s2", {4'b0, leds()}, 8'h0f);
        bus.i_btn = 1'b0;
        step(8);

        bus.i_btn = 1'b1;
        step(5);
        chk("t4_fill_mode", {6'b0, bus.o_mode}, 8'h02);
        chk("t4_fill_init", {4'b0, leds()}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(4);
            chk("t4_fill_step", {4'b0, leds()}, {4'b0, exp_f[i]});
        end
        bus.i_btn = 1'b0;
        step(8);

        bus.i_btn = 1'b1;
        step(5);
        chk("t4_alt_mode", {6'b0, bus.o_mode}, 8'h03);
        chk("t4_alt_init", {4'b0, leds()}, 8'h05);
        step(4);
        chk("t4_alt_s1", {4'b0, leds()}, 8'h0a);
        step(4);
        chk("t4_alt_s2", {4'b0, leds()}, 8'h05);
        bus.i_btn = 1'b0;
        step(8);

        bus.i_btn = 1'b1;
        step(5);
        chk("t4_bounce_mode", {6'b0, bus.o_mode}, 8'h00);
        chk("t4_bounce_init", {4'b0, leds()}, 8'h01);
        step(4);
        chk("t4_bounce_s1", {4'b0, leds()}, 8'h02);
        bus.i_btn = 1'b0;

        // 5: pause holds pattern and prescaler
        step(4);
        chk("t5_at_0100", {4'b0, leds()}, 8'h04);
        bus.i_pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t5_hold_leds", {4'b0, leds()}, 8'h04);
            chk("t5_hold_tick", {7'b0, bus.o_tick}, 8'h00);
        end
        bus.i_pause = 1'b0;
        step(3);
        chk("t5_resume_wait", {4'b0, leds()}, 8'h04);
        step(1);
        chk("t5_resume_step", {4'b0, leds()}, 8'h08);
        chk("t5_resume_tick", {7'b0, bus.o_tick}, 8'h01);

        // 6: advance coincident with prescaler wrap, then async reset mid-FILL
        do_reset();
        step(3);
        bus.i_btn = 1'b1;
        step(4);
        chk("t6_pre_mode", {6'b0, bus.o_mode}, 8'h00);
        chk("t6_pre_leds", {4'b0, leds()}, 8'h02);
        step(1);
        chk("t6_adv_mode", {6'b0, bus.o_mode}, 8'h01);
        chk("t6_adv_leds", {4'b0, leds()}, 8'h0f);
        chk("t6_adv_tick", {7'b0, bus.o_tick}, 8'h00);
        step(4);
        chk("t6_next_leds", {4'b0, leds()}, 8'h00);
        chk("t6_next_tick", {7'b0, bus.o_tick}, 8'h01);
        bus.i_btn = 1'b0;
        step(8);
        bus.i_btn = 1'b1;
        step(5);
        chk("t6_fill_mode", {6'b0, bus.o_mode}, 8'h02);
        bus.i_btn = 1'b0;
        step(4);
        chk("t6_fill_s1", {4'b0, leds()}, 8'h01);
        step(4);
        chk("t6_fill_s2", {4'b0, leds()}, 8'h03);
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mode", {6'b0, bus.o_mode}, 8'h00);
        chk("t6_async_leds", {4'b0, leds()}, 8'h01);
        chk("t6_async_tick", {7'b0, bus.o_tick}, 8'h00);
        step(2);
        rst = 1'b0;
        step(4);
        chk("t6_post_leds", {4'b0, leds()}, 8'h02);
        chk("t6_post_tick", {7'b0, bus.o_tick}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
